// File: rtl/fv_obi_mem_responder_if.sv
// OBI-style request/response bundle for fv_obi_mem_responder.
// Every field packs all ports side by side, port p in its own slice.
interface fv_obi_mem_responder_if #(
  parameter int N_PORTS = 2,
  parameter int DEPTH   = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N_PORTS-1:0]    req_i;
  logic [N_PORTS-1:0]    gnt_o;
  logic [N_PORTS*32-1:0] addr_i;
  logic [N_PORTS-1:0]    we_i;
  logic [N_PORTS*4-1:0]  be_i;
  logic [N_PORTS*32-1:0] wdata_i;
  logic [N_PORTS-1:0]    stall_i;
  logic [N_PORTS-1:0]    rsp_stall_i;
  logic [N_PORTS*32-1:0] rdata_rand_i;
  logic [N_PORTS-1:0]    rvalid_o;
  logic [N_PORTS*32-1:0] rdata_o;
  logic [N_PORTS*CW-1:0] outstanding_o;
  logic [N_PORTS-1:0]    err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, stall_i, rsp_stall_i, rdata_rand_i,
    input  gnt_o, rvalid_o, rdata_o, outstanding_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, stall_i, rsp_stall_i, rdata_rand_i,
    output gnt_o, rvalid_o, rdata_o, outstanding_o, err_o
  );
endinterface

// File: rtl/fv_obi_mem_responder.sv
// Multi-port OBI-style memory responder for formal/sim harnesses.
// Each port grants requests (with bounded random stalls), keeps granted
// requests in an in-order FIFO, answers them after at least LAT cycles and
// flags handshake violations with a sticky error bit.
module fv_obi_mem_responder #(
  parameter int N_PORTS   = 2,
  parameter int DEPTH     = 2,
  parameter int LAT       = 1,
  parameter int MAX_STALL = 4
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  fv_obi_mem_responder_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (LAT > 2) ? $clog2(LAT - 1) : 1;
  localparam int SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

  // The push cycle already counts as one of the LAT cycles, so a new entry
  // starts at LAT-2; with LAT=1 an empty FIFO answers in the grant cycle.
  localparam logic [RW-1:0] REM_INIT  = RW'((LAT >= 2) ? LAT - 2 : 0);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [RW-1:0]    rem_q [DEPTH];
    logic [RW-1:0]    rem_d [DEPTH];
    logic [DEPTH-1:0] we_q, we_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    stallCnt_q, stallCnt_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic [31:0]      pAddr_q, pWdata_q;
    logic [3:0]       pBe_q;
    logic             pWe_q;

    logic        req, we, stall, rspStall;
    logic [31:0] addr, wdata, rnd;
    logic [3:0]  be;
    logic        gnt, forced, headReady, bypass, pop, popWe, viol;

    assign req      = bus.req_i[p];
    assign we       = bus.we_i[p];
    assign stall    = bus.stall_i[p];
    assign rspStall = bus.rsp_stall_i[p];
    assign addr     = bus.addr_i[p*32 +: 32];
    assign wdata    = bus.wdata_i[p*32 +: 32];
    assign rnd      = bus.rdata_rand_i[p*32 +: 32];
    assign be       = bus.be_i[p*4 +: 4];

    assign bus.gnt_o[p]                = gnt;
    assign bus.rvalid_o[p]             = rvalid_q;
    assign bus.rdata_o[p*32 +: 32]     = rdata_q;
    assign bus.outstanding_o[p*CW +: CW] = count_q;
    assign bus.err_o[p]                = err_q;

    // Grant and response selection; a full FIFO never grants, even on a pop.
    always_comb begin
      forced    = (MAX_STALL != 0) && (stallCnt_q == STALL_MAX);
      gnt       = req && (count_q < CNT_FULL) && (!stall || forced);
      headReady = (count_q != '0) && (rem_q[rdPtr_q] == '0);
      bypass    = (LAT == 1) && (count_q == '0) && gnt;
      pop       = (headReady || bypass) && !rspStall;
      popWe     = headReady ? we_q[rdPtr_q] : we;
    end

    // FIFO, stall counter and registered response next-state.
    always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
        rem_d[i] = (rem_q[i] != '0) ? rem_q[i] - 1'b1 : '0;
      end
      we_d       = we_q;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      stallCnt_d = stallCnt_q;
      if (gnt) begin
        rem_d[wrPtr_q] = REM_INIT;
        we_d[wrPtr_q]  = we;
        wrPtr_d        = ptrInc(wrPtr_q);
      end
      if (pop) begin
        rdPtr_d = ptrInc(rdPtr_q);
      end
      if (gnt && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!gnt && pop) begin
        count_d = count_q - 1'b1;
      end
      if (!req || gnt) begin
        stallCnt_d = '0;
      end else if (stallCnt_q < STALL_MAX) begin
        stallCnt_d = stallCnt_q + 1'b1;
      end
      rvalid_d = pop;
      rdata_d  = (pop && !popWe) ? rnd : '0;
    end

    // Protocol checker: a stalled request must be held stable until granted.
    always_comb begin
      viol = 1'b0;
      if (pend_q && (!req || addr != pAddr_q || we != pWe_q || be != pBe_q ||
                     (we && wdata != pWdata_q))) begin
        viol = 1'b1;
      end
      if (gnt && we && be == 4'h0) begin
        viol = 1'b1;
      end
      err_d  = err_q || viol;
      pend_d = req && !gnt;
    end

    // State registers; reset drops every in-flight request.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          rem_q[i] <= '0;
        end
        we_q       <= '0;
        wrPtr_q    <= '0;
        rdPtr_q    <= '0;
        count_q    <= '0;
        stallCnt_q <= '0;
        rvalid_q   <= 1'b0;
        rdata_q    <= '0;
        err_q      <= 1'b0;
        pend_q     <= 1'b0;
        pAddr_q    <= '0;
        pWdata_q   <= '0;
        pBe_q      <= '0;
        pWe_q      <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          rem_q[i] <= rem_d[i];
        end
        we_q       <= we_d;
        wrPtr_q    <= wrPtr_d;
        rdPtr_q    <= rdPtr_d;
        count_q    <= count_d;
        stallCnt_q <= stallCnt_d;
        rvalid_q   <= rvalid_d;
        rdata_q    <= rdata_d;
        err_q      <= err_d;
        pend_q     <= pend_d;
        pAddr_q    <= addr;
        pWdata_q   <= wdata;
        pBe_q      <= be;
        pWe_q      <= we;
      end
    end
  end
endmodule

// File: tb/tb_fv_obi_mem_responder.sv
// Directed bench for fv_obi_mem_responder (N_PORTS=2, DEPTH=2, LAT=3, MAX_STALL=4).
// Port 0 runs a per-cycle vector table; hand sequences cover port 1,
// reset behaviour and the zero-byte-enable write error.
module tb_fv_obi_mem_responder;
  logic clk_i = 1'b0;
  logic rst_n_i;
  int   total = 0;
  int   bad   = 0;

  fv_obi_mem_responder_if #(.N_PORTS(2), .DEPTH(2)) bus ();

  fv_obi_mem_responder #(
    .N_PORTS(2), .DEPTH(2), .LAT(3), .MAX_STALL(4)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stall, rsp;
    logic [31:0] rnd;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic [1:0]  outs;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic req, logic we, logic [31:0] addr, logic [3:0] be,
                              logic [31:0] wdata, logic stall, logic rsp, logic [31:0] rnd,
                              logic gnt, logic rvalid, logic [31:0] rdata, logic [1:0] outs,
                              logic err);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
    v.stall = stall; v.rsp = rsp; v.rnd = rnd;
    v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.outs = outs; v.err = err;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.req_i[0]              = v.req;
    bus.we_i[0]               = v.we;
    bus.addr_i[31:0]          = v.addr;
    bus.be_i[3:0]             = v.be;
    bus.wdata_i[31:0]         = v.wdata;
    bus.stall_i[0]            = v.stall;
    bus.rsp_stall_i[0]        = v.rsp;
    bus.rdata_rand_i[31:0]    = v.rnd;
  endtask

  task automatic drivePort1(input logic req, input logic [31:0] addr, input logic [31:0] rnd);
    bus.req_i[1]           = req;
    bus.we_i[1]            = 1'b0;
    bus.addr_i[63:32]      = addr;
    bus.be_i[7:4]          = 4'hF;
    bus.wdata_i[63:32]     = '0;
    bus.stall_i[1]         = 1'b0;
    bus.rsp_stall_i[1]     = 1'b0;
    bus.rdata_rand_i[63:32] = rnd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Port 0 vectors: one row per cycle, expectations worked out by hand.
    // Single read, LAT=3: granted c0, data sampled c2, rvalid c3.
    vecs.push_back(mk(1,0,32'h1000,4'hF,0,0,0,32'h11,       1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'h22,                 0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'hDEADBEEF,           0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'h33,                 0,1,32'hDEADBEEF,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'h44,                 0,0,0,0,0));
    // Back-to-back reads fill the FIFO; the third waits for the first pop.
    vecs.push_back(mk(1,0,32'h10,4'hF,0,0,1,32'h01,         1,0,0,0,0));
    vecs.push_back(mk(1,0,32'h14,4'hF,0,0,1,32'h02,         1,0,0,1,0));
    vecs.push_back(mk(1,0,32'h18,4'hF,0,0,1,32'h03,         0,0,0,2,0));
    vecs.push_back(mk(1,0,32'h18,4'hF,0,0,1,32'h04,         0,0,0,2,0));
    vecs.push_back(mk(1,0,32'h18,4'hF,0,0,0,32'hA1,         0,0,0,2,0));
    vecs.push_back(mk(1,0,32'h18,4'hF,0,0,0,32'hB2,         1,1,32'hA1,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'hC3,                 0,1,32'hB2,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'hD4,                 0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'hE5,                 0,1,32'hD4,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'hF6,                 0,0,0,0,0));
    // Held stall: grant forced on the fifth request cycle.
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,32'h200,4'hF,0,1,0,32'h50, 0,0,0,0,0));
    vecs.push_back(mk(1,0,32'h200,4'hF,0,1,0,32'h51,        1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'h52,                 0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'h55,                 0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'h56,                 0,1,32'h55,0,0));
    // Write answers with zero data regardless of the random source.
    vecs.push_back(mk(1,1,32'h300,4'hF,32'h12345678,0,0,32'hFFFF, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'hAAAA,               0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'hBBBB,               0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'hCCCC,               0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,32'h0,                  0,0,0,0,0));
    // Address changes under stall: sticky error.
    vecs.push_back(mk(1,0,32'h100,4'hF,0,1,0,0,             0,0,0,0,0));
    vecs.push_back(mk(1,0,32'h104,4'hF,0,1,0,0,             0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,                      0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,                      0,0,0,0,1));

    // Reset with a request pending: grant follows req, everything else zero.
    rst_n_i = 1'b0;
    applyStimulus(mk(1,0,32'h0,4'hF,0,0,0,32'h9,0,0,0,0,0));
    drivePort1(1'b0, '0, '0);
    #1;
    nextCycle();
    nextCycle();
    checkOutput("rst.gnt",    32'(bus.gnt_o[0]),        1);
    checkOutput("rst.rvalid", 32'(bus.rvalid_o[0]),     0);
    checkOutput("rst.err",    32'(bus.err_o[0]),        0);
    checkOutput("rst.outs",   32'(bus.outstanding_o[1:0]), 0);
    bus.req_i[0] = 1'b0;
    nextCycle();
    rst_n_i = 1'b1;
    #1;
    checkOutput("post_rst.rvalid", 32'(bus.rvalid_o[0]),     0);
    checkOutput("post_rst.outs",   32'(bus.outstanding_o[1:0]), 0);
    checkOutput("post_rst.rdata",  bus.rdata_o[31:0],        0);
    nextCycle();

    // Table-driven main run on port 0 while port 1 stays idle.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.gnt", i),    32'(bus.gnt_o[0]),          32'(vecs[i].gnt));
      checkOutput($sformatf("v%0d.rvalid", i), 32'(bus.rvalid_o[0]),       32'(vecs[i].rvalid));
      checkOutput($sformatf("v%0d.rdata", i),  bus.rdata_o[31:0],          vecs[i].rdata);
      checkOutput($sformatf("v%0d.outs", i),   32'(bus.outstanding_o[1:0]), 32'(vecs[i].outs));
      checkOutput($sformatf("v%0d.err", i),    32'(bus.err_o[0]),          32'(vecs[i].err));
      checkOutput($sformatf("v%0d.p1rv", i),   32'(bus.rvalid_o[1]),       0);
      checkOutput($sformatf("v%0d.p1err", i),  32'(bus.err_o[1]),          0);
      nextCycle();
    end

    // Port 1 read is independent of port 0's sticky error.
    applyStimulus(mk(0,0,0,0,0,0,0,32'h99,0,0,0,0,0));
    drivePort1(1'b1, 32'h40, 32'h70);
    #1;
    checkOutput("p1.gnt", 32'(bus.gnt_o[1]), 1);
    nextCycle();
    drivePort1(1'b0, '0, 32'h71);
    #1;
    checkOutput("p1.outs", 32'(bus.outstanding_o[3:2]), 1);
    nextCycle();
    drivePort1(1'b0, '0, 32'h77);
    nextCycle();
    drivePort1(1'b0, '0, 32'h78);
    #1;
    checkOutput("p1.rvalid",  32'(bus.rvalid_o[1]),  1);
    checkOutput("p1.rdata",   bus.rdata_o[63:32],    32'h77);
    checkOutput("p1.p0rv",    32'(bus.rvalid_o[0]),  0);
    checkOutput("p1.p0err",   32'(bus.err_o[0]),     1);
    nextCycle();

    // Reset clears the sticky error.
    rst_n_i = 1'b0;
    #1;
    checkOutput("clr.err", 32'(bus.err_o[0]), 0);
    nextCycle();
    rst_n_i = 1'b1;

    // Granted write with no byte enables raises the error.
    applyStimulus(mk(1,1,32'h500,4'h0,32'h1,0,1,32'h5,0,0,0,0,0));
    #1;
    checkOutput("be0.gnt", 32'(bus.gnt_o[0]), 1);
    checkOutput("be0.err", 32'(bus.err_o[0]), 0);
    nextCycle();
    applyStimulus(mk(1,0,32'h504,4'hF,0,0,1,32'h6,0,0,0,0,0));
    #1;
    checkOutput("be0.err_set", 32'(bus.err_o[0]), 1);
    checkOutput("be0.gnt2",    32'(bus.gnt_o[0]), 1);
    nextCycle();
    applyStimulus(mk(0,0,0,0,0,0,1,32'h7,0,0,0,0,0));
    #1;
    checkOutput("mid.outs2", 32'(bus.outstanding_o[1:0]), 2);

    // Reset with two requests in flight: nothing is ever answered.
    rst_n_i = 1'b0;
    #1;
    checkOutput("mid.outs0",  32'(bus.outstanding_o[1:0]), 0);
    checkOutput("mid.err",    32'(bus.err_o[0]),          0);
    nextCycle();
    rst_n_i = 1'b1;
    applyStimulus(mk(0,0,0,0,0,0,0,32'h8,0,0,0,0,0));
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput($sformatf("drop%0d.rvalid", i), 32'(bus.rvalid_o[0]),       0);
      checkOutput($sformatf("drop%0d.outs", i),   32'(bus.outstanding_o[1:0]), 0);
      nextCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
